// File: rtl/gate_response_checker_pkg.sv
// Shared definitions for the gate response checker: FSM state encoding,
// reference truth tables for common 2-input gates, and sweep helpers.
// No ports; imported by the checker top and its settle timer.
package gate_response_checker_pkg;

  // Checker FSM states (3-bit encoding, values fixed for debug visibility)
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Reference truth tables; bit i = expected output for stim == i
  localparam logic [3:0] TT_AND2 = 4'b1000;
  localparam logic [3:0] TT_OR2  = 4'b1110;
  localparam logic [3:0] TT_XOR2 = 4'b0110;

  // Settle counter width (SETTLE range 1..15)
  localparam int SETTLE_W = 4;

  // Number of input vectors swept for an n_in-input gate
  function automatic int sweep_len(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/gate_response_checker_if.sv
// Bundle of the checker's control and gate-side signals.
// master: the checker (drives stim and the result signals, receives start/dut_y).
// slave : the surrounding wrapper and gate DUT (drives start and dut_y).
interface gate_response_checker_if #(
  parameter int N_IN  = 2,
  parameter int ERR_W = 8
);
  logic             start;          // 1-cycle start pulse
  logic             dut_y;          // gate output under test
  logic [N_IN-1:0]  stim;           // gate inputs, MSB = first gate input
  logic             busy;           // sweep in progress
  logic             done;           // sweep finished, result valid
  logic             pass;           // done with zero mismatches
  logic [ERR_W-1:0] err_count;      // saturating mismatch count
  logic [N_IN-1:0]  first_err_idx;  // stim index of first mismatch

  modport master (
    input  start, dut_y,
    output stim, busy, done, pass, err_count, first_err_idx
  );

  modport slave (
    output start, dut_y,
    input  stim, busy, done, pass, err_count, first_err_idx
  );
endinterface

// File: rtl/gate_response_checker_chk_settle_timer.sv
// chk_settle_timer: loadable 4-bit down-counter that stops at zero.
// Latency: load takes effect on the next edge; expired is combinational from the count.
// Ports: clk, rst (sync, active-high), load/load_val, en (decrement), expired (count == 0).
module chk_settle_timer
  import gate_response_checker_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                en,
  output logic                expired
);

  logic [SETTLE_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/gate_response_checker.sv
// gate_response_checker: sweeps all 2**N_IN vectors into a gate and checks dut_y against TRUTH.
// Latency: SETTLE+2 cycles per vector; done rises 2**N_IN*(SETTLE+2) cycles after the start edge.
// Backpressure: start is ignored while busy; a start in DONE restarts immediately.
// Ports: clk (rising edge), rst (sync, active-high), bus (gate_response_checker_if.master).
// Build option: CHECKER_STOP_ON_FAIL_EN -- when defined, the first mismatch ends the sweep
// with stim holding the failing vector; otherwise every vector is checked.
module gate_response_checker
  import gate_response_checker_pkg::*;
#(
  parameter int                      N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]    TRUTH  = TT_OR2,
  parameter int                      SETTLE = 1,
  parameter int                      ERR_W  = 8
)(
  input  logic                       clk,
  input  logic                       rst,
  gate_response_checker_if.master    bus
);

  // idx carries one extra bit so the last-vector comparison never wraps
  localparam logic [N_IN:0] LAST = {1'b0, {N_IN{1'b1}}};

  state_t           state;
  logic [N_IN:0]    idx;
  logic [N_IN-1:0]  stim_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [N_IN-1:0]  first_err_q;

  logic             settle_expired;
  logic             mismatch;
  logic             last_step;
  logic [ERR_W-1:0] err_nxt;

  chk_settle_timer u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (state == S_DRIVE),
    .load_val (SETTLE_W'(SETTLE - 1)),
    .en       (state == S_WAIT),
    .expired  (settle_expired)
  );

  assign mismatch = (bus.dut_y != TRUTH[idx[N_IN-1:0]]);

  // Saturating mismatch counter update, used only in CHECK
  always_comb begin
    err_nxt = err_q;
    if (mismatch && (err_q != {ERR_W{1'b1}})) begin
      err_nxt = err_q + 1'b1;
    end
  end

`ifdef CHECKER_STOP_ON_FAIL_EN
  assign last_step = (idx == LAST) || mismatch;
`else
  assign last_step = (idx == LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      stim_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      first_err_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            err_q       <= '0;
            first_err_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b1;
            idx         <= '0;
            state       <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          stim_q <= idx[N_IN-1:0];
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (settle_expired) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          err_q <= err_nxt;
          // err_q only returns to zero on start/rst, so zero means no earlier mismatch
          if (mismatch && (err_q == '0)) begin
            first_err_q <= idx[N_IN-1:0];
          end
          if (last_step) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            pass_q <= (err_nxt == '0);
          end else begin
            idx   <= idx + 1'b1;
            state <= S_DRIVE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.stim          = stim_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = first_err_q;

endmodule
